// File: rtl/nes_poll_scheduler.sv
// rtl/nes_poll_scheduler.sv - periodic two-pad NES scan sequencer with APB3 register front-end
module nes_poll_scheduler #(
    parameter int HALF_TICKS = 300,
    parameter int POLL_TICKS = 833333
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        nes_latch,
    output logic        nes_clock,
    input  logic        nes_data1,
    input  logic        nes_data2,
    output logic        irq
);
    localparam int TW = $clog2(2 * HALF_TICKS);
    localparam int PW = $clog2(POLL_TICKS);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_TICKS - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_TICKS - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [2:0]    bit_idx, bit_n;
    logic          sample_en, start;
    logic [PW-1:0] poll_cnt;
    logic          pending;
    logic [1:0]    sync1, sync2;
    logic [7:0]    shift1, shift2, pad1, pad2, poll_count;
    logic [15:0]   press, press_set, press_clr;
    logic          ctrl_enable, ctrl_irq_en;
    logic          wr_en, rd_setup, poll_req, timer_wrap, busy;
    logic [4:0]    addr;
    logic [31:0]   rd_data;
    logic          unused_bits;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign addr        = PADDR[4:0];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign rd_setup    = PSEL & ~PENABLE & ~PWRITE;
    assign poll_req    = wr_en && (addr == 5'h0C) && PWDATA[2];
    assign timer_wrap  = (poll_cnt == POLL_LAST);
    assign busy        = (state != S_IDLE) | pending;
    assign unused_bits = ^PWDATA[31:16] ^ ^PADDR[31:5];

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sync1[0], nes_data1};
            sync2 <= {sync2[0], nes_data2};
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            poll_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            poll_cnt <= timer_wrap ? '0 : poll_cnt + 1'b1;
            // A request landing on the consuming cycle is kept for the following scan
            pending  <= (pending & ~start) | (timer_wrap & ctrl_enable) | poll_req;
        end
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick + 1'b1;
        bit_n     = bit_idx;
        sample_en = 1'b0;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                tick_n = '0;
                if (pending) begin
                    start   = 1'b1;
                    state_n = S_LATCH;
                end
            end
            S_LATCH: begin
                if (tick == LATCH_LAST) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = S_LOW;
                end
            end
            S_LOW: begin
                if (tick == HALF_LAST) begin
                    tick_n    = '0;
                    sample_en = 1'b1;
                    state_n   = (bit_idx == 3'd7) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick == HALF_LAST) begin
                    tick_n  = '0;
                    bit_n   = bit_idx + 1'b1;
                    state_n = S_LOW;
                end
            end
            S_DONE: begin
                tick_n  = '0;
                state_n = S_IDLE;
            end
            default: begin
                tick_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Pad lines are registered from the next state so they track it without decode glitches
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state     <= S_IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            nes_latch <= 1'b0;
            nes_clock <= 1'b0;
        end else begin
            state     <= state_n;
            tick      <= tick_n;
            bit_idx   <= bit_n;
            nes_latch <= (state_n == S_LATCH);
            nes_clock <= (state_n == S_HIGH);
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            shift1 <= '0;
            shift2 <= '0;
        end else if (sample_en) begin
            shift1[bit_idx] <= ~sync1[1];
            shift2[bit_idx] <= ~sync2[1];
        end
    end

    assign press_set = (state == S_DONE) ? {shift2 & ~pad2, shift1 & ~pad1} : 16'h0000;
    assign press_clr = (wr_en && addr == 5'h08) ? PWDATA[15:0] : 16'h0000;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            pad1        <= '0;
            pad2        <= '0;
            press       <= '0;
            poll_count  <= '0;
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            press <= (press & ~press_clr) | press_set;
            if (state == S_DONE) begin
                pad1       <= shift1;
                pad2       <= shift2;
                poll_count <= poll_count + 1'b1;
            end
            if (wr_en && addr == 5'h0C) begin
                ctrl_enable <= PWDATA[0];
                ctrl_irq_en <= PWDATA[1];
            end
            irq <= ctrl_irq_en & (|press);
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            5'h00:   rd_data[7:0]  = pad1;
            5'h04:   rd_data[7:0]  = pad2;
            5'h08:   rd_data[15:0] = press;
            5'h0C:   rd_data[1:0]  = {ctrl_irq_en, ctrl_enable};
            5'h10:   rd_data[8:0]  = {busy, poll_count};
            default: rd_data       = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN)
            PRDATA <= '0;
        else if (rd_setup)
            PRDATA <= rd_data;
    end
endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb/tb_nes_poll_scheduler.sv - directed self-checking bench for nes_poll_scheduler
module tb_nes_poll_scheduler;
    localparam int HALF = 4;
    localparam int POLL = 200;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, nes_latch, nes_clock, irq;
    logic        nes_data1, nes_data2;

    logic [7:0]  raw1 = 8'hFF, raw2 = 8'hFF;
    logic [2:0]  pidx = 3'd0;
    int          errors = 0, checks = 0;
    int          cyc = 0, latch_rises = 0, last_rise = 0;
    logic        prev_latch = 1'b0;

    nes_poll_scheduler #(.HALF_TICKS(HALF), .POLL_TICKS(POLL)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .nes_latch(nes_latch), .nes_clock(nes_clock), .nes_data1(nes_data1),
        .nes_data2(nes_data2), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Pad model: latch reloads bit 0, each clock rise presents the next bit
    always @(posedge nes_latch or posedge nes_clock) begin
        if (nes_latch) pidx <= 3'd0;
        else           pidx <= pidx + 3'd1;
    end
    assign nes_data1 = raw1[pidx];
    assign nes_data2 = raw2[pidx];

    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) begin
        if (nes_latch && !prev_latch) begin
            latch_rises = latch_rises + 1;
            last_rise   = cyc;
        end
        prev_latch = nes_latch;
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wait_scan(input int bound, output bit seen);
        int r0;
        r0 = latch_rises;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge PCLK);
            if (latch_rises != r0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        PRESERN = 1'b0;
        idle(3);
        checks++; if (nes_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", nes_latch); end
        checks++; if (nes_clock !== 1'b0) begin errors++; $display("FAIL reset_clock: got %b expected 0", nes_clock); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected 0", PRDATA); end
        checks++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_ready_err: got %b%b expected 10", PREADY, PSLVERR); end
        PRESERN = 1'b1;
        apb_read(32'h10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_scan;
        logic [31:0] d;
        bit seen;
        int lc, ch, pulses, last_fall, irq_at, overlap;
        logic pc;
        raw1 = 8'hFE; raw2 = 8'hFF;
        apb_write(32'h0C, 32'h3);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge PCLK);
            if (nes_latch) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL scan_start_timeout: got none expected latch within 400"); end
        lc = 0; ch = 0; pulses = 0; last_fall = -1; irq_at = -1; overlap = 0; pc = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge PCLK);
            if (nes_latch) lc++;
            if (nes_clock) ch++;
            if (nes_clock && !pc) pulses++;
            if (!nes_clock && pc) last_fall = k;
            if (nes_latch && nes_clock) overlap++;
            if (irq && irq_at < 0) irq_at = k;
            pc = nes_clock;
        end
        checks++; if (lc != 8) begin errors++; $display("FAIL latch_cycles: got %0d expected 8", lc); end
        checks++; if (pulses != 7) begin errors++; $display("FAIL clock_pulses: got %0d expected 7", pulses); end
        checks++; if (ch != 28) begin errors++; $display("FAIL clock_high_cycles: got %0d expected 28", ch); end
        checks++; if (last_fall != 64) begin errors++; $display("FAIL last_clock_fall: got %0d expected 64", last_fall); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL latch_clock_overlap: got %0d expected 0", overlap); end
        // DONE at cycle 68, PRESS visible at 69, irq register one cycle later
        checks++; if (irq_at != 70) begin errors++; $display("FAIL irq_latency: got %0d expected 70", irq_at); end
        apb_read(32'h00, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL pad1: got %h expected 01", d); end
        apb_read(32'h04, d);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL pad2: got %h expected 00", d); end
        apb_read(32'h08, d);
        checks++; if (d !== 32'h0001) begin errors++; $display("FAIL press_first: got %h expected 0001", d); end
        apb_read(32'h10, d);
        checks++; if (d !== 32'h001) begin errors++; $display("FAIL status_count1: got %h expected 001", d); end
        apb_read(32'h18, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped: got %h expected 0", d); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        bit seen;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
        apb_write(32'h08, 32'h0001);
        idle(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
        apb_read(32'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL press_w1c: got %h expected 0", d); end
        wait_scan(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL held_scan_timeout: got none expected scan"); end
        idle(75);
        apb_read(32'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL press_held: got %h expected 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_held: got %b expected 0", irq); end
        apb_read(32'h10, d);
        checks++; if (d !== 32'h002) begin errors++; $display("FAIL status_count2: got %h expected 002", d); end
    endtask

    task automatic test_press_edges;
        logic [31:0] d;
        bit seen;
        raw2 = 8'hFE;
        wait_scan(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL pad2a_scan_timeout: got none expected scan"); end
        idle(75);
        apb_read(32'h08, d);
        checks++; if (d !== 32'h0100) begin errors++; $display("FAIL press_pad2_a: got %h expected 0100", d); end
        apb_write(32'h08, 32'h0100);
        raw2 = 8'h7E;
        wait_scan(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL pad2r_scan_timeout: got none expected scan"); end
        idle(75);
        apb_read(32'h08, d);
        checks++; if (d !== 32'h8000) begin errors++; $display("FAIL press_pad2_right: got %h expected 8000", d); end
        apb_read(32'h04, d);
        checks++; if (d !== 32'h81) begin errors++; $display("FAIL pad2_right_a: got %h expected 81", d); end
        apb_write(32'h0C, 32'h0);
    endtask

    task automatic test_poll_now;
        logic [31:0] d;
        int r0;
        PRESERN = 1'b0;
        idle(3);
        PRESERN = 1'b1;
        r0 = latch_rises;
        apb_write(32'h0C, 32'h4);
        idle(3);
        apb_read(32'h10, d);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL pn_busy_early: got %h expected 100", d); end
        idle(40);
        apb_read(32'h10, d);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL pn_busy_late: got %h expected 100", d); end
        idle(60);
        apb_read(32'h10, d);
        checks++; if (d !== 32'h001) begin errors++; $display("FAIL pn_count: got %h expected 001", d); end
        apb_read(32'h0C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL pn_ctrl_read: got %h expected 0", d); end
        idle(300);
        checks++; if (latch_rises - r0 != 1) begin errors++; $display("FAIL pn_scan_count: got %0d expected 1", latch_rises - r0); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int l0, b, r;
        apb_write(32'h0C, 32'h1);
        wait_scan(250, seen);
        checks++; if (!seen) begin errors++; $display("FAIL b2b_timer_timeout: got none expected scan"); end
        l0 = last_rise;
        r  = latch_rises;
        // Next timer wrap falls at l0+198, inside the poll_now scan started near l0+153
        while (cyc < l0 + 150) @(negedge PCLK);
        apb_write(32'h0C, 32'h5);
        wait_scan(30, seen);
        checks++; if (!seen) begin errors++; $display("FAIL b2b_pollnow_timeout: got none expected scan"); end
        b = last_rise;
        idle(20);
        apb_write(32'h0C, 32'h5);
        wait_scan(100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL b2b_extra_timeout: got none expected scan"); end
        apb_write(32'h0C, 32'h0);
        checks++; if (last_rise - b != 70) begin errors++; $display("FAIL b2b_gap: got %0d expected 70", last_rise - b); end
        idle(450);
        checks++; if (latch_rises - r != 2) begin errors++; $display("FAIL b2b_scan_count: got %0d expected 2", latch_rises - r); end
    endtask

    task automatic test_reset_midscan;
        logic [31:0] d;
        bit seen;
        int l0, rel;
        apb_write(32'h0C, 32'h1);
        wait_scan(250, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rm_scan_timeout: got none expected scan"); end
        l0 = last_rise;
        while (cyc < l0 + 37) @(negedge PCLK);
        checks++; if (nes_clock !== 1'b1) begin errors++; $display("FAIL rm_in_high3: got %b expected 1", nes_clock); end
        #2 PRESERN = 1'b0;
        #1;
        checks++; if (nes_clock !== 1'b0 || nes_latch !== 1'b0) begin errors++; $display("FAIL rm_lines: got %b%b expected 00", nes_latch, nes_clock); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rm_prdata: got %h expected 0", PRDATA); end
        idle(2);
        PRESERN = 1'b1;
        rel = cyc;
        apb_read(32'h00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_pad1: got %h expected 0", d); end
        apb_read(32'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_press: got %h expected 0", d); end
        apb_read(32'h10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_status: got %h expected 0", d); end
        apb_write(32'h0C, 32'h1);
        wait_scan(260, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rm_rescan_timeout: got none expected scan"); end
        checks++; if (last_rise - rel != 201) begin errors++; $display("FAIL rm_first_scan: got %0d expected 201", last_rise - rel); end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_irq;
        test_press_edges;
        test_poll_now;
        test_back_to_back;
        test_reset_midscan;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nes_poll_scheduler.md
Name: nes_poll_scheduler

Overview:
- Autonomous scan sequencer and APB3 register front-end for two NES-style serial gamepads.
- The two pads share the latch and clock lines; each has its own data line.
- Scans both pads periodically with no CPU involvement, keeps the current button state and sticky per-button press events, and raises an interrupt on a new press.
- Sits on the APB3 fabric beside the other game peripherals; the fabric decodes PSEL, this block decodes PADDR[4:0].

Parameters:
- HALF_TICKS, 300, PCLK cycles per half bit-period (6 us at 50 MHz); must be ≥2.
- POLL_TICKS, 833333, PCLK cycles between scan starts (60 Hz at 50 MHz); must be > 17*HALF_TICKS+2.

Ports:
- PCLK  in  1  clock
- PRESERN  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  32  APB address; only [4:0] decoded
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- nes_latch  out  1  shared pad latch
- nes_clock  out  1  shared pad clock
- nes_data1  in  1  pad 1 serial data, active-low
- nes_data2  in  1  pad 2 serial data, active-low
- irq  out  1  interrupt, level, active-high

Behaviour:
- Reset (async, PRESERN=0): all registers 0, FSM=IDLE, nes_latch=0, nes_clock=0, PRDATA=0, irq=0, timers 0.
- Synchronisers: nes_data1 and nes_data2 each pass through 2 flops before use. "Sample" below means the synchronised value.
- Poll timer:
  - Free-running; counts 0..POLL_TICKS-1 and wraps.
  - On wrap, sets pending if CTRL.enable=1.
  - A write of CTRL.poll_now=1 sets pending regardless of enable.
- FSM states:
  - IDLE: latch=0, clock=0. If pending: clear pending, go to LATCH.
  - LATCH: latch=1 for 2*HALF_TICKS cycles, then LOW with bit=0.
  - LOW: clock=0 for HALF_TICKS cycles. On the last cycle, shift1[bit]=~sample1 and shift2[bit]=~sample2. If bit==7 go to DONE, else go to HIGH.
  - HIGH: clock=1 for HALF_TICKS cycles, then bit++ and go to LOW.
  - DONE: one cycle. PAD1<=shift1, PAD2<=shift2, PRESS|={new2&~PAD2_old, new1&~PAD1_old}, poll_count++ (8-bit, wraps 255→0). Then go to IDLE.
- Timing and bit order:
  - One scan, from LATCH entry to DONE inclusive, takes 17*HALF_TICKS+1 cycles.
  - Bit 0 is the first serial bit (A); bit order is A,B,Select,Start,Up,Down,Left,Right.
- Outputs: nes_latch and nes_clock are registered, glitch-free, and never high simultaneously.
- Pending: a pending request arriving during a scan is held and starts the next scan immediately after DONE. Multiple requests collapse into one.
- Clearing CTRL.enable mid-scan does not abort the scan; it only blocks future timer-driven scans.
- APB read:
  - PRDATA is registered on the setup phase (PSEL&~PENABLE&~PWRITE) and is valid in the access phase.
  - Unmapped offsets read 0.
- APB write: takes effect on PSEL&PENABLE&PWRITE.
- Register map (offsets):
  - 0x00 PAD1: RO, [7:0] current pad 1 buttons, 1=pressed.
  - 0x04 PAD2: RO, [7:0] current pad 2 buttons.
  - 0x08 PRESS: [7:0] pad1 / [15:8] pad2 press events.
    - Write 1 to clear (W1C).
    - If a set in DONE and a clear land in the same cycle, the set wins.
  - 0x0C CTRL: [0] enable, [1] irq_en (both RW); [2] poll_now (write-only, reads 0).
  - 0x10 STATUS: RO, [7:0] poll_count, [8] busy (FSM≠IDLE or pending).
- irq = CTRL.irq_en & |PRESS, registered (one-cycle lag).
- Reset mid-scan: outputs drop to 0 asynchronously. PAD and PRESS keep no partial data; all are 0.

Test Plan:
- HALF_TICKS=4, POLL_TICKS=200, enable=1, pad1 shifts 0xFE (A pressed), pad2 0xFF → latch high 8 cycles, 8 clock-low and 7 clock-high pulses of 4 cycles; PAD1=0x01, PAD2=0x00, PRESS=0x0001, 69 cycles from LATCH entry to DONE.
- irq_en=1 after the above → irq=1. Write 0x0001 to PRESS → irq=0. Next scan with the same buttons leaves PRESS=0 (no re-trigger while held).
- Pad2 A held, then Right+A in the next scan → PRESS[15:8]=0x80 only.
- enable=0, write CTRL.poll_now=1 → exactly one scan; STATUS.busy=1 throughout; poll_count increments 0→1; no further scans.
- poll_now written mid-scan plus a timer wrap → exactly one extra scan, starting the cycle after DONE.
- PRESERN pulsed low during HIGH of bit 3 → latch=0, clock=0, all registers 0 immediately. After release, the first scan starts only at the next timer wrap.
